note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player.sv | 115 +++++++++++
 tb/tb_note_player.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// note_player
//   Plays one note at a time. The note is timed in beats, and while it sounds
//   a 22-bit phase accumulator is advanced on codec sample ticks.
//
// Ports
//   clk          in   1   single clock; all logic on its rising edge
//   reset        in   1   synchronous, active-high
//   play         in   1   1 = run, 0 = pause (beat and sample_tick ignored)
//   beat         in   1   one-cycle duration-time strobe
//   sample_tick  in   1   one-cycle strobe at the codec sample rate
//   new_note     in   1   one-cycle strobe; note and duration valid with it
//   note         in   6   note code, 0 = rest
//   duration     in   6   note length in beats
//   note_done    out  1   one-cycle pulse requesting the next note
//   note_active  out  1   high while a non-rest note is sounding
//   cur_note     out  6   latched note code
//   phase        out 22   phase accumulator for the waveform ROM
module note_player (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        beat,
    input  logic        sample_tick,
    input  logic        new_note,
    input  logic [5:0]  note,
    input  logic [5:0]  duration,
    output logic        note_done,
    output logic        note_active,
    output logic [5:0]  cur_note,
    output logic [21:0] phase
);

    typedef enum logic {IDLE, PLAYING} state_t;

    state_t      state;
    logic [5:0]  beat_cnt;
    logic        ld_p1;      // high in the cycle after a load: step_p1 is stale
    logic [19:0] step_p1;    // registered frequency step for cur_note

    // Frequency step table: 48 kHz sample rate, 2^22 phase range.
    // Note 1 is C2; each group of 12 notes is one octave up (step doubled).
    function automatic logic [19:0] frequency_rom(input logic [5:0] n);
        logic [5:0]  k;
        logic [2:0]  oct;
        logic [3:0]  semi;
        logic [19:0] base;
        k    = n - 6'd1;
        oct  = 3'(k / 6'd12);
        semi = 4'(k % 6'd12);
        case (semi)
            4'd0:    base = 20'd5716;
            4'd1:    base = 20'd6056;
            4'd2:    base = 20'd6416;
            4'd3:    base = 20'd6797;
            4'd4:    base = 20'd7201;
            4'd5:    base = 20'd7629;
            4'd6:    base = 20'd8083;
            4'd7:    base = 20'd8564;
            4'd8:    base = 20'd9073;
            4'd9:    base = 20'd9612;
            4'd10:   base = 20'd10184;
            default: base = 20'd10789;
        endcase
        if (n == 6'd0)
            return 20'd0;
        return base << oct;
    endfunction

    // Stage p1: step lookup, one cycle behind cur_note
    always_ff @(posedge clk) begin
        step_p1 <= frequency_rom(cur_note);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= 6'd0;
            cur_note    <= 6'd0;
            phase       <= 22'd0;
            note_active <= 1'b0;
            note_done   <= 1'b0;
            ld_p1       <= 1'b0;
        end else begin
            note_done <= 1'b0;
            ld_p1     <= new_note;
            if (new_note) begin
                // A load preempts anything in flight, including a same-cycle beat.
                cur_note <= note;
                phase    <= 22'd0;
                beat_cnt <= duration;
                if (duration == 6'd0) begin
                    state       <= IDLE;
                    note_done   <= 1'b1;
                    note_active <= 1'b0;
                end else begin
                    state       <= PLAYING;
                    note_active <= (note != 6'd0);
                end
            end else if (state == PLAYING && play) begin
                // Two cycles after a load the step register holds the new note's step.
                if (sample_tick && cur_note != 6'd0 && !ld_p1)
                    phase <= phase + {2'b00, step_p1};
                if (beat && beat_cnt != 6'd0) begin
                    beat_cnt <= beat_cnt - 6'd1;
                    if (beat_cnt == 6'd1) begin
                        state       <= IDLE;
                        note_done   <= 1'b1;
                        note_active <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    logic        clk = 1'b0;
    logic        reset, play, beat, sample_tick, new_note;
    logic [5:0]  note, duration;
    logic        note_done, note_active;
    logic [5:0]  cur_note;
    logic [21:0] phase;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    note_player dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .sample_tick(sample_tick), .new_note(new_note), .note(note),
        .duration(duration), .note_done(note_done), .note_active(note_active),
        .cur_note(cur_note), .phase(phase)
    );

    typedef struct {
        logic       rst, ply, bt, tk, nn;
        logic [5:0] nt, du;
        logic       done, act;
        logic [5:0] cur;
    } vec_t;

    vec_t tbl[$];
    longint fstep[64];

    function automatic vec_t mk(input logic rst, ply, bt, tk, nn,
                                input logic [5:0] nt, du,
                                input logic done, act, input logic [5:0] cur);
        vec_t v;
        v.rst = rst; v.ply = ply; v.bt = bt; v.tk = tk; v.nn = nn;
        v.nt = nt; v.du = du; v.done = done; v.act = act; v.cur = cur;
        return v;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input logic rst, ply, bt, tk, nn, input logic [5:0] nt, du);
        reset = rst; play = ply; beat = bt; sample_tick = tk;
        new_note = nn; note = nt; duration = du;
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Behavioural model: what a listener would observe
    bit     m_busy;
    int     m_left;
    int     m_note;
    longint m_phase;
    int     m_age;
    bit     m_done;

    task automatic model_step();
        bit fin;
        fin = 0;
        if (reset) begin
            m_busy = 0; m_left = 0; m_note = 0; m_phase = 0; m_done = 0; m_age = 2;
        end else if (new_note) begin
            m_note = note; m_phase = 0; m_age = 0;
            m_left = duration;
            m_busy = (duration != 0);
            m_done = (duration == 0);
        end else begin
            m_done = 0;
            if (m_busy && play) begin
                if (sample_tick && m_note != 0 && m_age >= 1)
                    m_phase = (m_phase + fstep[m_note]) % (64'd1 << 22);
                if (beat) begin
                    m_left = m_left - 1;
                    if (m_left == 0) fin = 1;
                end
            end
            if (fin) begin
                m_busy = 0; m_done = 1;
            end
            if (m_age < 2) m_age++;
        end
    endtask

    initial begin
        int base [12] = '{5716, 6056, 6416, 6797, 7201, 7629, 8083, 8564,
                          9073, 9612, 10184, 10789};
        fstep[0] = 0;
        for (int n = 1; n < 64; n++)
            fstep[n] = longint'(base[(n - 1) % 12]) * (64'd1 << ((n - 1) / 12));

        // rst ply bt tk nn note dur | done act cur
        tbl.push_back(mk(1,0,0,0,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,0,0));   // beat in idle
        tbl.push_back(mk(0,1,0,0,1,10,3, 0,1,10));  // normal note
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,10));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,1,10));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,10));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,10));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,10));
        tbl.push_back(mk(0,1,0,0,1, 5,2, 0,1,5));   // pause
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,5));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,1,1,0, 0,0, 0,1,5));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,5));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,5));
        tbl.push_back(mk(0,1,1,0,1, 7,4, 0,1,7));   // load + beat collision
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,7));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,7));
        tbl.push_back(mk(0,1,0,0,1, 9,1, 0,1,9));   // preempt, no done
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,1,9));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,9));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,9));
        tbl.push_back(mk(0,1,1,0,1, 7,4, 0,1,7));   // counter reloaded to 4
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,0,0, 0,0, 0,1,7));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,7));
        tbl.push_back(mk(0,1,0,0,1, 3,0, 1,0,3));   // duration 0
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,3));
        tbl.push_back(mk(0,1,0,0,1, 0,2, 0,0,0));   // rest
        tbl.push_back(mk(0,1,1,1,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,1,1,1,0, 0,0, 1,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1,12,1, 0,1,12));  // load while paused
        tbl.push_back(mk(0,0,1,0,0, 0,0, 0,1,12));
        tbl.push_back(mk(0,1,1,0,0, 0,0, 1,0,12));
        tbl.push_back(mk(0,1,0,0,1,15,5, 0,1,15));  // reset mid-note
        tbl.push_back(mk(1,1,1,1,0, 0,0, 0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,1,0, 0,0, 0,0,0));

        drive(1,0,0,0,0,0,0);
        tick_clk();
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ply, tbl[i].bt, tbl[i].tk, tbl[i].nn,
                  tbl[i].nt, tbl[i].du);
            tick_clk();
            chk("tbl_note_done",   note_done,   tbl[i].done);
            chk("tbl_note_active", note_active, tbl[i].act);
            chk("tbl_cur_note",    cur_note,    tbl[i].cur);
            chk("tbl_phase",       phase,       0);
        end

        // Phase accumulation and wrap for note 20, ticks from the load cycle on
        begin
            longint exp_ph;
            exp_ph = 0;
            drive(0,1,0,1,1,20,63);
            tick_clk();
            chk("ph_load", phase, 0);
            drive(0,1,0,1,0,0,0);
            tick_clk();
            chk("ph_load_plus1", phase, 0);
            for (int k = 0; k < 260; k++) begin
                tick_clk();
                exp_ph = (exp_ph + 17128) % (64'd1 << 22);
                chk("ph_accum", phase, exp_ph);
            end
            drive(0,0,1,1,0,0,0);
            for (int k = 0; k < 4; k++) begin
                tick_clk();
                chk("ph_paused", phase, exp_ph);
            end
            chk("ph_active", note_active, 1);
        end

        // Randomized run against the model
        drive(1,0,0,0,0,0,0);
        model_step();
        tick_clk();
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(4) != 0),
                  ($urandom_range(2) == 0), ($urandom_range(1) == 0),
                  ($urandom_range(11) == 0), 6'($urandom_range(63)),
                  6'($urandom_range(5)));
            model_step();
            tick_clk();
            chk("rnd_note_done",   note_done,   m_done);
            chk("rnd_note_active", note_active, m_busy && m_note != 0);
            chk("rnd_cur_note",    cur_note,    m_note);
            chk("rnd_phase",       phase,       m_phase);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
